// File: rtl/cpu_decode_pkg.sv
// Shared encodings for the Moxie decode stage: instruction forms, FSM states,
// register index names and the set of opcodes that carry a 32-bit immediate.
package cpu_decode_pkg;

  typedef enum logic [1:0] {
    FORM1 = 2'd0,
    FORM2 = 2'd2,
    FORM3 = 2'd3
  } form_e;

  typedef enum logic [1:0] {
    ST_OP     = 2'd0,
    ST_IMM_HI = 2'd1,
    ST_IMM_LO = 2'd2,
    ST_ISSUE  = 2'd3
  } state_e;

  localparam logic [3:0] REG_FP = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_R0 = 4'd2;

  // form1 opcodes followed by two immediate halfwords
  function automatic logic is_long(input logic [7:0] opcode);
    case (opcode)
      8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d,
      8'h1f, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: is_long = 1'b1;
      default: is_long = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// Fetch-to-decode halfword stream and decode-to-execute bundle handshake.
interface cpu_decode_if;
  logic        fetch_valid_i;
  logic [15:0] fetch_data_i;
  logic        fetch_ready_o;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [1:0]  dec_form_o;
  logic [7:0]  dec_opcode_o;
  logic [3:0]  dec_rega_o;
  logic [3:0]  dec_regb_o;
  logic [31:0] dec_imm_o;
  logic        dec_long_o;

  modport master (
    output fetch_valid_i, fetch_data_i, dec_ready_i,
    input  fetch_ready_o, dec_valid_o, dec_form_o, dec_opcode_o,
           dec_rega_o, dec_regb_o, dec_imm_o, dec_long_o
  );

  modport slave (
    input  fetch_valid_i, fetch_data_i, dec_ready_i,
    output fetch_ready_o, dec_valid_o, dec_form_o, dec_opcode_o,
           dec_rega_o, dec_regb_o, dec_imm_o, dec_long_o
  );
endinterface

// File: rtl/cpu_decode_fields.sv
// Combinational field extraction for one opcode halfword: form, opcode,
// register fields, read indices and extended immediate.
module cpu_decode_fields
  import cpu_decode_pkg::*;
(
  input  logic [15:0] hw,
  output form_e       form,
  output logic [7:0]  opcode,
  output logic [3:0]  rega,
  output logic [3:0]  regb,
  output logic [3:0]  index1,
  output logic [3:0]  index2,
  output logic [31:0] imm,
  output logic        long_op
);

  always_comb begin
    form    = FORM1;
    opcode  = hw[15:8];
    rega    = hw[7:4];
    regb    = hw[3:0];
    index1  = hw[7:4];
    index2  = hw[3:0];
    imm     = 32'd0;
    long_op = 1'b0;
    if (!hw[15]) begin
      long_op = is_long(hw[15:8]);
    end else if (!hw[14]) begin
      form   = FORM2;
      opcode = {6'd0, hw[13:12]};
      rega   = hw[11:8];
      regb   = 4'd0;
      index1 = hw[11:8];
      index2 = hw[11:8];
      imm    = {24'd0, hw[7:0]};
    end else begin
      // branch offset is in halfwords, so scale by two after sign extension
      form   = FORM3;
      opcode = {4'd0, hw[13:10]};
      rega   = 4'd0;
      regb   = 4'd0;
      index1 = REG_FP;
      index2 = REG_FP;
      imm    = {{21{hw[9]}}, hw[9:0], 1'b0};
    end
  end

endmodule

// File: rtl/cpu_decode.sv
// Moxie decode stage: assembles long instructions, strobes the register-file
// read port and holds the decoded bundle for execute.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_OP     | waiting for an opcode halfword
// ST_IMM_HI | waiting for immediate bits [31:16]
// ST_IMM_LO | waiting for immediate bits [15:0]
// ST_ISSUE  | bundle held on dec_valid_o until execute takes it
module cpu_decode
  import cpu_decode_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  cpu_decode_if.slave  bus,
  output logic [3:0]   reg_read_index1_o,
  output logic [3:0]   reg_read_index2_o,
  output logic         read_enable_o
);

  state_e      state_q, state_d;
  logic        fetch_ready;
  logic        accept;
  logic        op_accept;

  form_e       f_form;
  logic [7:0]  f_opcode;
  logic [3:0]  f_rega, f_regb, f_index1, f_index2;
  logic [31:0] f_imm;
  logic        f_long;

  form_e       form_q;
  logic [7:0]  opcode_q;
  logic [3:0]  rega_q, regb_q;
  logic [31:0] imm_q;
  logic        long_q;
  logic        valid_q;

  cpu_decode_fields u_fields (
    .hw      (bus.fetch_data_i),
    .form    (f_form),
    .opcode  (f_opcode),
    .rega    (f_rega),
    .regb    (f_regb),
    .index1  (f_index1),
    .index2  (f_index2),
    .imm     (f_imm),
    .long_op (f_long)
  );

  // ready depends on dec_ready_i so a handoff and the next opcode share a cycle
  assign fetch_ready = !rst_i && (state_q != ST_ISSUE || bus.dec_ready_i);
  assign accept      = bus.fetch_valid_i && fetch_ready && !flush_i;
  assign op_accept   = accept && (state_q == ST_OP || state_q == ST_ISSUE);

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_OP;
    end else begin
      case (state_q)
        ST_OP: begin
          if (accept) state_d = f_long ? ST_IMM_HI : ST_ISSUE;
        end
        ST_IMM_HI: begin
          if (accept) state_d = ST_IMM_LO;
        end
        ST_IMM_LO: begin
          if (accept) state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (accept) state_d = f_long ? ST_IMM_HI : ST_ISSUE;
          else if (bus.dec_ready_i) state_d = ST_OP;
        end
        default: state_d = ST_OP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= ST_OP;
      read_enable_o     <= 1'b0;
      reg_read_index1_o <= 4'd0;
      reg_read_index2_o <= 4'd0;
      form_q            <= FORM1;
      opcode_q          <= 8'd0;
      rega_q            <= 4'd0;
      regb_q            <= 4'd0;
      imm_q             <= 32'd0;
      long_q            <= 1'b0;
      valid_q           <= 1'b0;
    end else begin
      state_q       <= state_d;
      read_enable_o <= op_accept;
      if (op_accept) begin
        reg_read_index1_o <= f_index1;
        reg_read_index2_o <= f_index2;
        form_q            <= f_form;
        opcode_q          <= f_opcode;
        rega_q            <= f_rega;
        regb_q            <= f_regb;
        imm_q             <= f_imm;
        long_q            <= 1'b0;
        valid_q           <= !f_long;
      end else if (accept && state_q == ST_IMM_HI) begin
        imm_q[31:16] <= bus.fetch_data_i;
      end else if (accept && state_q == ST_IMM_LO) begin
        imm_q[15:0] <= bus.fetch_data_i;
        long_q      <= 1'b1;
        valid_q     <= 1'b1;
      end else if (state_q == ST_ISSUE && bus.dec_ready_i) begin
        valid_q <= 1'b0;
      end
      if (flush_i) valid_q <= 1'b0;
    end
  end

  assign bus.fetch_ready_o = fetch_ready;
  assign bus.dec_valid_o   = valid_q;
  assign bus.dec_form_o    = form_q;
  assign bus.dec_opcode_o  = opcode_q;
  assign bus.dec_rega_o    = rega_q;
  assign bus.dec_regb_o    = regb_q;
  assign bus.dec_imm_o     = imm_q;
  assign bus.dec_long_o    = long_q;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: reset, short/long/form2/form3 decode,
// backpressure handoff, flush and mid-instruction reset.
module tb_cpu_decode;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [3:0] idx1, idx2;
  logic re;
  int n_assert = 0;
  int n_fail = 0;

  cpu_decode_if bus ();

  cpu_decode dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .bus               (bus),
    .reg_read_index1_o (idx1),
    .reg_read_index2_o (idx2),
    .read_enable_o     (re)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d);
    bus.fetch_valid_i = v;
    bus.fetch_data_i  = d;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.dec_ready_i = 1'b1;
    drive(1'b1, 16'h0234);

    // reset held two cycles with a halfword offered
    step();
    chk("rst_ready", bus.fetch_ready_o, 0);
    chk("rst_valid", bus.dec_valid_o, 0);
    chk("rst_re", re, 0);
    step();
    chk("rst_ready2", bus.fetch_ready_o, 0);
    chk("rst_imm", bus.dec_imm_o, 0);
    chk("rst_idx1", idx1, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", bus.fetch_ready_o, 1);

    // form1 short 0x0234, then 0x0256 back to back
    step();
    chk("s1_re", re, 1);
    chk("s1_idx1", idx1, 3);
    chk("s1_idx2", idx2, 4);
    chk("s1_valid", bus.dec_valid_o, 1);
    chk("s1_opcode", bus.dec_opcode_o, 8'h02);
    chk("s1_long", bus.dec_long_o, 0);
    chk("s1_form", bus.dec_form_o, 0);
    drive(1'b1, 16'h0256);
    step();
    chk("s2_re", re, 1);
    chk("s2_idx1", idx1, 5);
    chk("s2_idx2", idx2, 6);
    chk("s2_valid", bus.dec_valid_o, 1);
    chk("s2_rega", bus.dec_rega_o, 5);

    // long 0x0120 DEAD BEEF
    drive(1'b1, 16'h0120);
    step();
    chk("l_re", re, 1);
    chk("l_idx1", idx1, 2);
    chk("l_valid0", bus.dec_valid_o, 0);
    drive(1'b1, 16'hDEAD);
    step();
    chk("l_re_hi", re, 0);
    chk("l_valid_hi", bus.dec_valid_o, 0);
    chk("l_idx1_hold", idx1, 2);
    drive(1'b1, 16'hBEEF);
    step();
    chk("l_re_lo", re, 0);
    chk("l_valid", bus.dec_valid_o, 1);
    chk("l_imm", bus.dec_imm_o, 32'hDEADBEEF);
    chk("l_rega", bus.dec_rega_o, 2);
    chk("l_long", bus.dec_long_o, 1);
    chk("l_opcode", bus.dec_opcode_o, 8'h01);

    // form2 0x8580
    drive(1'b1, 16'h8580);
    step();
    chk("f2_form", bus.dec_form_o, 2);
    chk("f2_rega", bus.dec_rega_o, 5);
    chk("f2_regb", bus.dec_regb_o, 0);
    chk("f2_imm", bus.dec_imm_o, 32'h00000080);
    chk("f2_opcode", bus.dec_opcode_o, 0);
    chk("f2_long", bus.dec_long_o, 0);
    chk("f2_idx1", idx1, 5);
    chk("f2_idx2", idx2, 5);
    chk("f2_re", re, 1);

    // form3 0xC3FF
    drive(1'b1, 16'hC3FF);
    step();
    chk("f3_form", bus.dec_form_o, 3);
    chk("f3_imm", bus.dec_imm_o, 32'hFFFFFFFE);
    chk("f3_opcode", bus.dec_opcode_o, 0);
    chk("f3_idx1", idx1, 0);
    chk("f3_valid", bus.dec_valid_o, 1);

    // backpressure: hold the form3 bundle with 0x0256 offered
    drive(1'b1, 16'h0256);
    bus.dec_ready_i = 1'b0;
    #1;
    chk("bp_ready_pre", bus.fetch_ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", bus.dec_valid_o, 1);
      chk("bp_imm", bus.dec_imm_o, 32'hFFFFFFFE);
      chk("bp_form", bus.dec_form_o, 3);
      chk("bp_ready", bus.fetch_ready_o, 0);
      chk("bp_re", re, 0);
    end
    bus.dec_ready_i = 1'b1;
    #1;
    chk("bp_ready_up", bus.fetch_ready_o, 1);
    step();
    chk("bp_hand_form", bus.dec_form_o, 0);
    chk("bp_hand_opcode", bus.dec_opcode_o, 8'h02);
    chk("bp_hand_rega", bus.dec_rega_o, 5);
    chk("bp_hand_valid", bus.dec_valid_o, 1);
    chk("bp_hand_re", re, 1);

    // idle with execute ready drains the bundle
    drive(1'b0, 16'h0000);
    step();
    chk("idle_valid", bus.dec_valid_o, 0);
    chk("idle_re", re, 0);

    // flush mid long instruction
    drive(1'b1, 16'h0120);
    step();
    chk("fl_re", re, 1);
    drive(1'b1, 16'h1234);
    step();
    drive(1'b1, 16'h5678);
    flush = 1'b1;
    step();
    chk("fl_valid", bus.dec_valid_o, 0);
    chk("fl_re0", re, 0);
    // flush also beats an opcode offered in OP
    drive(1'b1, 16'h0234);
    step();
    chk("fl_op_valid", bus.dec_valid_o, 0);
    chk("fl_op_re", re, 0);
    flush = 1'b0;
    step();
    chk("fr_valid", bus.dec_valid_o, 1);
    chk("fr_long", bus.dec_long_o, 0);
    chk("fr_opcode", bus.dec_opcode_o, 8'h02);
    chk("fr_imm", bus.dec_imm_o, 0);
    chk("fr_re", re, 1);
    chk("fr_idx2", idx2, 4);

    // reset mid long instruction discards the partial immediate
    drive(1'b1, 16'h0120);
    step();
    drive(1'b1, 16'hAAAA);
    step();
    rst = 1'b1;
    step();
    chk("mr_imm", bus.dec_imm_o, 0);
    chk("mr_valid", bus.dec_valid_o, 0);
    chk("mr_idx1", idx1, 0);
    rst = 1'b0;
    drive(1'b1, 16'h8580);
    step();
    chk("mr_f2_imm", bus.dec_imm_o, 32'h00000080);
    chk("mr_f2_valid", bus.dec_valid_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_decode.md
# cpu_decode

Moxie instruction decode stage, directly upstream of the register file. Accepts 16-bit instruction halfwords from fetch, collects the 32-bit trailing immediate of long instructions, and drives the register-file read port (indices plus a one-cycle read enable). Presents a decoded instruction bundle to execute over a valid/ready handshake, and supports a flush for taken branches.

## Interface
- No parameters. All encoding constants live in `cpu_decode_pkg`.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `fetch_valid_i` in 1: `fetch_data_i` holds a valid halfword.
- `fetch_data_i` in 16: instruction halfword, big-endian stream order.
- `fetch_ready_o` out 1: decode accepts the halfword this cycle.
- `flush_i` in 1: discard the in-progress and pending instruction.
- `reg_read_index1_o` out 4: register-file read index 1 (0=$fp, 1=$sp, 2..15=$r0..$r13).
- `reg_read_index2_o` out 4: register-file read index 2.
- `read_enable_o` out 1: one-cycle read strobe to the register file.
- `dec_valid_o` out 1: decoded bundle valid.
- `dec_ready_i` in 1: execute accepts the bundle.
- `dec_form_o` out 2: 0 = form1, 2 = form2, 3 = form3.
- `dec_opcode_o` out 8: form1 uses [15:8]; form2/3 zero-extend their 2/4-bit opcode.
- `dec_rega_o` out 4: A register field.
- `dec_regb_o` out 4: B register field, 0 for form2/3.
- `dec_imm_o` out 32: immediate or offset.
- `dec_long_o` out 1: instruction carried a 32-bit immediate.

## Operation
- **States:** OP (await opcode halfword), IMM_HI, IMM_LO, ISSUE (bundle held on `dec_valid_o`).
- A halfword is accepted when `fetch_valid_i && fetch_ready_o`.
- `fetch_ready_o` = `!rst_i && (state != ISSUE || dec_ready_i)`. This includes a combinational path from `dec_ready_i`, so an ISSUE handoff and the next opcode acceptance share a cycle.
- **Opcode accepted in OP (or in ISSUE with `dec_ready_i`):**
  - Classify by bits [15:14]: `0x` → form1, `10` → form2, `11` → form3.
  - **form1:** opcode = [15:8], A = [7:4], B = [3:0]. index1 = A, index2 = B.
  - **form2:** opcode = [13:12], A = [11:8], imm = zero-extended [7:0]. index1 = index2 = A.
  - **form3:** opcode = [13:10], imm = sign-extended [9:0] shifted left 1, so imm bit 0 is always 0. Indices are 0.
  - Register indices and assert `read_enable_o` for the following cycle.
  - Next state is IMM_HI if form1 and the opcode is in the package LONG_OPCODES set: 0x01, 0x03, 0x08, 0x09, 0x0c, 0x0d, 0x1a, 0x1b, 0x1d, 0x1f, 0x20, 0x22, 0x24, 0x36, 0x37, 0x38, 0x39. Otherwise next state is ISSUE.
- **IMM_HI accept:** imm[31:16] ← halfword; go to IMM_LO.
- **IMM_LO accept:** imm[15:0] ← halfword; `dec_long_o` ← 1; go to ISSUE.
- **ISSUE:** bundle held stable while `dec_ready_i` is low. On `dec_ready_i`:
  - If a new opcode is accepted in the same cycle, decode it as above.
  - Otherwise go to OP and drop `dec_valid_o`.
- Register indices hold their last value between opcodes. `read_enable_o` is never asserted for immediate halfwords.
- **flush_i:** next state is OP and `dec_valid_o` ← 0.
  - Any halfword presented in the same cycle is dropped: flush wins over acceptance.
  - A `read_enable_o` already scheduled for the next cycle is suppressed.
- **Reset:** state OP. Every output is 0: indices, `read_enable_o`, `dec_valid_o`, form, opcode, rega, regb, imm, long, and `fetch_ready_o`. Reset mid-instruction discards partial immediates.

## Timing
- Opcode accepted at edge N:
  - `read_enable_o` and indices are valid during cycle N+1.
  - Register-file data is available from N+2.
- Short instruction: `dec_valid_o` rises in cycle N+1, coincident with `read_enable_o`.
- Long instruction, with halfwords accepted at N, M and K (M, K ≥ N+1): `read_enable_o` is high during N+1 only, and `dec_valid_o` rises at K+1.
- Sustained throughput is one short instruction per cycle. A long instruction takes 3 cycles minimum.
- `read_enable_o` is a single-cycle pulse, never held high on consecutive cycles for the same opcode.

## Structure
- `cpu_decode_pkg` holds:
  - the form encodings;
  - the state enum;
  - the LONG_OPCODES set with an `is_long(opcode)` function;
  - the register index constants (REG_FP = 0, REG_SP = 1, REG_R0 = 2).
- One sub-module, `cpu_decode_fields`: the combinational field extraction and immediate sign/zero extension for one halfword. It is reused by any future predecoder.

## Test plan
- **Reset:** `rst_i` high for 2 cycles with `fetch_valid_i` = 1 → `fetch_ready_o` = 0, `dec_valid_o` = 0, `read_enable_o` = 0. After release, `fetch_ready_o` = 1.
- **form1 short:** 0x0234 → next cycle `read_enable_o` = 1, index1 = 3, index2 = 4, `dec_valid_o` = 1, opcode 0x02, long = 0. Back-to-back with 0x0256 issues the next bundle in the next cycle.
- **Long:** 0x0120, 0xDEAD, 0xBEEF on consecutive cycles → `read_enable_o` high once (index1 = 2), then `dec_valid_o` with imm 0xDEADBEEF, rega 2, long = 1.
- **form2 and form3:**
  - 0x8580 → form 2, rega 5, imm 0x00000080.
  - 0xC3FF → form 3, imm 0xFFFFFFFE.
- **Backpressure:** `dec_ready_i` low for 5 cycles with the next opcode offered → bundle stable, `fetch_ready_o` = 0. Raising `dec_ready_i` hands off and accepts the new opcode in the same cycle.
- **Flush:** 0x0120, 0x1234, then `flush_i` together with 0x5678 → no `dec_valid_o`. A following 0x0234 decodes as a fresh short instruction.
